// File: rtl/regfile_wr_arbiter.sv
// Purpose: owns the register-file write port; zero-fills all registers after reset, then round-robins two writers.
// Latency: one cycle from the grant edge to We/Wa/Wd; the clear sequence takes NREG cycles after reset.
// Backpressure: a requester holds Req/Addr/Data until it sees its combinational grant; no grants while clearing.
`timescale 1ns/1ps
module regfile_wr_arbiter #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          Req0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] Data0,
    output logic          Gnt0,
    input  logic          Req1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] Data1,
    output logic          Gnt1,
    output logic          We,
    output logic [AW-1:0] Wa,
    output logic [DW-1:0] Wd,
    output logic          Ready
);

    // Counter must be able to hold NREG itself, not just NREG-1.
    localparam int CW = $clog2(NREG + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ptr;   // 0: requester 0 wins a tie, 1: requester 1 wins
    logic          gnt0;
    logic          gnt1;

    // Grant decision: lone requester always wins, a tie goes to the pointer's favourite.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == RUN) begin
            gnt0 = Req0 && (!Req1 || !ptr);
            gnt1 = Req1 && (!Req0 ||  ptr);
        end
    end

    assign Gnt0 = gnt0;
    assign Gnt1 = gnt1;

    // Clear sequence, then registered write port driven by the granted requester.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state <= INIT;
            cnt   <= '0;
            ptr   <= 1'b0;
            We    <= 1'b0;
            Wa    <= '0;
            Wd    <= '0;
            Ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    // Address 0 is cleared too; only requester writes to it are dropped.
                    We  <= 1'b1;
                    Wa  <= AW'(cnt);
                    Wd  <= '0;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NREG - 1)) begin
                        state <= RUN;
                        Ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (gnt0) begin
                        // Register 0 is hardwired zero: consume the request but do not write.
                        We  <= (Addr0 != '0);
                        Wa  <= Addr0;
                        Wd  <= Data0;
                        ptr <= 1'b1;
                    end else if (gnt1) begin
                        We  <= (Addr1 != '0);
                        Wa  <= Addr1;
                        Wd  <= Data1;
                        ptr <= 1'b0;
                    end else begin
                        We <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                    We    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Purpose: bench for regfile_wr_arbiter; directed scenarios with literal expectations plus a random phase.
// Latency: outputs checked every negedge against a transaction-level model updated on each rising edge.
// Backpressure: stimulus holds each request until the model says it was granted, as the protocol requires.
`timescale 1ns/1ps
module tb_regfile_wr_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic          Clk;
    logic          Clrn;
    logic          Req0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] Data0;
    logic          Gnt0;
    logic          Req1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] Data1;
    logic          Gnt1;
    logic          We;
    logic [AW-1:0] Wa;
    logic [DW-1:0] Wd;
    logic          Ready;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wr_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Gnt0(Gnt0),
        .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Gnt1(Gnt1),
        .We(We), .Wa(Wa), .Wd(Wd), .Ready(Ready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int            m_cleared = 0;      // clear writes issued since reset
    int            m_fav     = 0;      // requester that wins a tie
    bit            m_took0   = 1'b0;   // request consumed at the last edge
    bit            m_took1   = 1'b0;
    logic          e_we      = 1'b0;
    logic [AW-1:0] e_wa      = '0;
    logic [DW-1:0] e_wd      = '0;
    logic          e_ready   = 1'b0;
    logic [DW-1:0] m_rf   [NREG];
    logic [DW-1:0] dut_rf [NREG];

    // Winner among current requesters: -1 none, else requester index.
    function automatic int pick(input logic r0, input logic r1, input int fav);
        if (r0 && r1) return fav;
        if (r0)       return 0;
        if (r1)       return 1;
        return -1;
    endfunction

    always @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            m_cleared = 0;
            m_fav     = 0;
            m_took0   = 1'b0;
            m_took1   = 1'b0;
            e_we      = 1'b0;
            e_wa      = '0;
            e_wd      = '0;
            e_ready   = 1'b0;
        end else begin
            m_took0 = 1'b0;
            m_took1 = 1'b0;
            if (m_cleared < NREG) begin
                e_we = 1'b1;
                e_wa = AW'(m_cleared);
                e_wd = '0;
                m_rf[m_cleared] = '0;
                m_cleared = m_cleared + 1;
                e_ready = (m_cleared == NREG);
            end else begin
                int w;
                w = pick(Req0, Req1, m_fav);
                if (w < 0) begin
                    e_we = 1'b0;
                end else begin
                    e_wa  = (w == 0) ? Addr0 : Addr1;
                    e_wd  = (w == 0) ? Data0 : Data1;
                    e_we  = (e_wa != 0);
                    if (e_we) m_rf[e_wa] = e_wd;
                    m_fav = 1 - w;
                    if (w == 0) m_took0 = 1'b1;
                    else        m_took1 = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge Clk) begin
        if (Clrn) begin
            int g;
            g = (m_cleared == NREG) ? pick(Req0, Req1, m_fav) : -1;
            chk("gnt0", 64'(Gnt0), 64'(g == 0));
            chk("gnt1", 64'(Gnt1), 64'(g == 1));
            chk("we", 64'(We), 64'(e_we));
            chk("ready", 64'(Ready), 64'(e_ready));
            if (e_we) begin
                chk("wa", 64'(Wa), 64'(e_wa));
                chk("wd", 64'(Wd), 64'(e_wd));
            end
            if (We && Wa < NREG) dut_rf[Wa] = Wd;
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        Clrn = 1'b0;
        Req0 = 1'b1; Addr0 = 5'd1; Data0 = 32'h55;
        Req1 = 1'b1; Addr1 = 5'd2; Data1 = 32'h66;
        #3;
        chk("rst_we", 64'(We), 64'd0);
        chk("rst_ready", 64'(Ready), 64'd0);
        chk("rst_gnt0", 64'(Gnt0), 64'd0);
        chk("rst_gnt1", 64'(Gnt1), 64'd0);
        chk("rst_wa", 64'(Wa), 64'd0);
        @(negedge Clk); #1;
        Clrn = 1'b1;

        // Clear sequence: Wa = 0..31, Wd = 0, no grants even with both requesting.
        for (int i = 0; i < NREG; i++) begin
            @(negedge Clk);
            chk("init_we", 64'(We), 64'd1);
            chk("init_wa", 64'(Wa), 64'(i));
            chk("init_wd", 64'(Wd), 64'd0);
            chk("init_gnt", 64'({Gnt0, Gnt1}), 64'd0);
            chk("init_ready", 64'(Ready), 64'(i == NREG - 1));
            if (i == 20) begin
                #1;
                Req0 = 1'b0;
                Req1 = 1'b0;
            end
        end
        @(negedge Clk);
        chk("idle_we", 64'(We), 64'd0);
        chk("idle_ready", 64'(Ready), 64'd1);

        // Lone requester 0.
        #1;
        Req0 = 1'b1; Addr0 = 5'd5; Data0 = 32'hDEADBEEF;
        #1;
        chk("solo_gnt0", 64'(Gnt0), 64'd1);
        @(negedge Clk);
        chk("solo_we", 64'(We), 64'd1);
        chk("solo_wa", 64'(Wa), 64'd5);
        chk("solo_wd", 64'(Wd), 64'hDEADBEEF);

        // Pointer now favours 1; requester 1 targets register 0 (dropped write).
        #1;
        Req0 = 1'b1; Addr0 = 5'd2; Data0 = 32'h77;
        Req1 = 1'b1; Addr1 = 5'd0; Data1 = 32'hFFFF;
        #1;
        chk("r0_gnt1", 64'(Gnt1), 64'd1);
        chk("r0_gnt0", 64'(Gnt0), 64'd0);
        @(negedge Clk);
        chk("r0_we", 64'(We), 64'd0);
        #1;
        Req1 = 1'b0;
        #1;
        chk("after_r0_gnt0", 64'(Gnt0), 64'd1);
        @(negedge Clk);
        chk("after_r0_we", 64'(We), 64'd1);
        chk("after_r0_wa", 64'(Wa), 64'd2);
        chk("after_r0_wd", 64'(Wd), 64'h77);

        // Both target register 9 with requester 1 favoured.
        #1;
        Req0 = 1'b1; Addr0 = 5'd9; Data0 = 32'hA;
        Req1 = 1'b1; Addr1 = 5'd9; Data1 = 32'hB;
        #1;
        chk("same_gnt1", 64'(Gnt1), 64'd1);
        @(negedge Clk);
        chk("same_first_wd", 64'(Wd), 64'hB);
        chk("same_first_wa", 64'(Wa), 64'd9);
        #1;
        Req1 = 1'b0;
        @(negedge Clk);
        chk("same_second_wd", 64'(Wd), 64'hA);
        chk("same_second_we", 64'(We), 64'd1);
        #1;
        Req0 = 1'b0;
        chk("reg9_final", 64'(dut_rf[9]), 64'hA);

        // One requester-1 write to return the tie-break to requester 0.
        Req1 = 1'b1; Addr1 = 5'd4; Data1 = 32'h44;
        @(negedge Clk);
        chk("r1_wa", 64'(Wa), 64'd4);
        chk("r1_wd", 64'(Wd), 64'h44);
        #1;

        // Continuous contention: grants alternate 0,1,0,1 then requester 0 drains.
        Req0 = 1'b1; Addr0 = 5'd3; Data0 = 32'h11;
        Req1 = 1'b1; Addr1 = 5'd7; Data1 = 32'h22;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("alt_gnt0", 64'(Gnt0), 64'(k % 2 == 0));
            chk("alt_gnt1", 64'(Gnt1), 64'(k % 2 == 1));
            @(negedge Clk);
            chk("alt_we", 64'(We), 64'd1);
            chk("alt_wa", 64'(Wa), (k % 2 == 0) ? 64'd3 : 64'd7);
            chk("alt_wd", 64'(Wd), (k % 2 == 0) ? 64'h11 : 64'h22);
            #1;
            if (k == 3) Req1 = 1'b0;
            if (k == 4) Req0 = 1'b0;
        end

        // Reset pulse while requester 0 holds a grant.
        Req0 = 1'b1; Addr0 = 5'd12; Data0 = 32'hCAFE;
        #1;
        chk("pre_rst_gnt0", 64'(Gnt0), 64'd1);
        #1;
        Clrn = 1'b0;
        #0.5;
        chk("pulse_we", 64'(We), 64'd0);
        chk("pulse_ready", 64'(Ready), 64'd0);
        chk("pulse_gnt0", 64'(Gnt0), 64'd0);
        #0.5;
        Clrn = 1'b1;
        Req0 = 1'b0;
        @(negedge Clk);
        chk("restart_we", 64'(We), 64'd1);
        chk("restart_wa", 64'(Wa), 64'd0);
        chk("restart_wd", 64'(Wd), 64'd0);
        chk("restart_ready", 64'(Ready), 64'd0);

        // Random phase: requests held until consumed, small address range for collisions and register 0.
        for (int c = 0; c < 800; c++) begin
            #1;
            if (!Req0 || m_took0) begin
                Req0  = ($urandom_range(0, 99) < 65);
                Addr0 = AW'($urandom_range(0, 7));
                Data0 = $urandom;
            end
            if (!Req1 || m_took1) begin
                Req1  = ($urandom_range(0, 99) < 65);
                Addr1 = AW'($urandom_range(0, 7));
                Data1 = $urandom;
            end
            if (c == 400) begin
                #2;
                Clrn = 1'b0;
                #1;
                Clrn = 1'b1;
            end
            @(negedge Clk);
        end
        #1;
        Req0 = 1'b0;
        Req1 = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        for (int r = 0; r < NREG; r++) begin
            chk("rf_final", 64'(dut_rf[r]), 64'(m_rf[r]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
